maze_controller: RTL

- FSM that sequences the maze-walk datapath: depth-first search from the datapath's reset location (8'h00) to a goal cell.
- Selects the direction, checks the boundary flag and the maze memory, and commands datapath register load, stack push, stack pop and stack readback.
- Marks visited cells in the maze memory.
- Sits between the top-level start/done/fail interface and the datapath plus maze memory.

---
 rtl/maze_controller_if.sv | 31 +++
 rtl/maze_controller.sv | 114 +++++++++++
 2 files changed

// File: rtl/maze_controller_if.sv
// Signal bundle between the maze controller, the start/done/fail host side and the
// walk datapath plus maze memory.
interface maze_controller_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             start;
  logic [7:0]       curLoc;
  logic             cntReach;
  logic             empStck;
  logic             memData;
  logic [1:0]       dir;
  logic             rgLd;
  logic             push;
  logic             pop;
  logic             readFromStack;
  logic             memWr;
  logic             busy;
  logic             done;
  logic             fail;
  logic [CNT_W-1:0] stepCnt;

  modport master (
    input  start, curLoc, cntReach, empStck, memData,
    output dir, rgLd, push, pop, readFromStack, memWr, busy, done, fail, stepCnt
  );

  modport slave (
    output start, curLoc, cntReach, empStck, memData,
    input  dir, rgLd, push, pop, readFromStack, memWr, busy, done, fail, stepCnt
  );
endinterface

// File: rtl/maze_controller.sv
// Depth-first maze-walk sequencer: marks cells, probes the four directions, then moves
// forward or backtracks through the datapath stack until the goal or a failure is reached.
module maze_controller #(
  parameter logic [7:0]       GOAL      = 8'hFF,
  parameter int unsigned      CNT_W     = 16,
  parameter logic [CNT_W-1:0] MAX_STEPS = CNT_W'(1024)
) (
  input logic               clk,
  input logic               rst,
  maze_controller_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StMark,
    StTry,
    StMove,
    StBack,
    StDone,
    StFail
  } state_e;

  state_e           stateQ, stateD;
  logic [1:0]       dirQ, dirD;
  logic [CNT_W-1:0] stepCntQ, stepCntD;
  logic [CNT_W-1:0] stepInc;
  logic             blocked;
  logic             atLimit;

  assign blocked = bus.cntReach | bus.memData;
  assign stepInc = (stepCntQ == '1) ? stepCntQ : stepCntQ + CNT_W'(1);
  // The transfer that reaches the limit still executes; only the follow-on state changes.
  assign atLimit = (stepInc >= MAX_STEPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ   <= StIdle;
      dirQ     <= 2'b00;
      stepCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      dirQ     <= dirD;
      stepCntQ <= stepCntD;
    end
  end

  always_comb begin
    stateD            = stateQ;
    dirD              = dirQ;
    stepCntD          = stepCntQ;
    bus.rgLd          = 1'b0;
    bus.push          = 1'b0;
    bus.pop           = 1'b0;
    bus.readFromStack = 1'b0;
    bus.memWr         = 1'b0;
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    bus.fail          = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (bus.start) stateD = StMark;
      end
      StMark: begin
        bus.memWr = 1'b1;
        bus.busy  = 1'b1;
        if (bus.curLoc == GOAL) begin
          stateD = StDone;
        end else begin
          dirD   = 2'b00;
          stateD = StTry;
        end
      end
      StTry: begin
        bus.busy = 1'b1;
        if (!blocked) begin
          stateD = StMove;
        end else if (dirQ != 2'b11) begin
          dirD = dirQ + 2'd1;
        end else begin
          stateD = StBack;
        end
      end
      StMove: begin
        bus.busy = 1'b1;
        bus.push = 1'b1;
        bus.rgLd = 1'b1;
        stepCntD = stepInc;
        stateD   = atLimit ? StFail : StMark;
      end
      StBack: begin
        bus.busy = 1'b1;
        // An empty stack means every reachable cell is exhausted: no transfer happens.
        if (bus.empStck) begin
          stateD = StFail;
        end else begin
          bus.pop           = 1'b1;
          bus.readFromStack = 1'b1;
          bus.rgLd          = 1'b1;
          stepCntD          = stepInc;
          dirD              = 2'b00;
          stateD            = atLimit ? StFail : StTry;
        end
      end
      StDone: bus.done = 1'b1;
      StFail: bus.fail = 1'b1;
      default: stateD = StIdle;
    endcase
  end

  assign bus.dir     = dirQ;
  assign bus.stepCnt = stepCntQ;

endmodule
